// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin stream arbiter.
// The beat struct is sized for the widest payload so bench components can share it.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_DATA_W = 1024;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A zero MAX_BEATS still needs a one-bit counter to keep the logic legal.
    function automatic int cnt_width(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  last;
        logic [3:0]            id;
    } arb_beat_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request strictly above last_grant, wrapping.
// The request vector is doubled so the wrap becomes a plain masked priority encode.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int IDX_W = idx_width(N_REQ);

    logic [2*N_REQ-1:0] req2_s;
    logic [2*N_REQ-1:0] mask2_s;
    logic [2*N_REQ-1:0] masked_s;

    // Mask off everything at or below last_grant, then take the lowest surviving bit.
    always_comb begin
        req2_s   = {req, req};
        mask2_s  = '0;
        winner   = '0;
        any      = |req;
        for (int i = 0; i < 2 * N_REQ; i++) begin
            mask2_s[i] = (i > int'(last_grant));
        end
        masked_s = req2_s & mask2_s;
        for (int i = 2 * N_REQ - 1; i >= 0; i--) begin
            winner = masked_s[i] ? IDX_W'(i % N_REQ) : winner;
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Packet-locked round-robin arbiter merging N_REQ valid/ready streams onto one.
// The grant is held from the first beat until the last beat (or forced release) is accepted.
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          s_valid,
    output logic [N_REQ-1:0]          s_ready,
    input  logic [N_REQ*DATA_W-1:0]   s_data,
    input  logic [N_REQ-1:0]          s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last,
    output logic [$clog2(N_REQ)-1:0]  m_id,
    output logic                      busy,
    output logic                      pkt_err
);

    localparam int              IDX_W     = idx_width(N_REQ);
    localparam int              CNT_W     = cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LIMIT = (MAX_BEATS == 0) ? '0 : CNT_W'(MAX_BEATS - 1);

    arb_state_e       state_r, state_s;
    logic [IDX_W-1:0] grant_r, grant_s;
    logic [IDX_W-1:0] last_grant_r, last_grant_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_s;
    logic             pkt_err_r, pkt_err_s;
    logic             pick_any_s;
    logic [IDX_W-1:0] pick_winner_s;
    logic             accept_s;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (s_valid),
        .last_grant (last_grant_r),
        .any        (pick_any_s),
        .winner     (pick_winner_s)
    );

    assign accept_s = m_valid & m_ready;
    assign pkt_err  = pkt_err_r;

    // Output pass-through from the granted requester while locked.
    always_comb begin
        s_ready = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_id    = grant_r;
        busy    = 1'b0;
        case (state_r)
            LOCKED: begin
                m_valid          = s_valid[grant_r];
                m_data           = s_data[int'(grant_r)*DATA_W +: DATA_W];
                m_last           = s_last[grant_r];
                s_ready[grant_r] = m_ready;
                busy             = 1'b1;
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Arbitration, packet tracking and forced release.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        beat_cnt_s   = beat_cnt_r;
        pkt_err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s    = LOCKED;
                    grant_s    = pick_winner_s;
                    beat_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOCKED: begin
                if (!accept_s) begin
                    state_s = LOCKED;
                end else if (m_last) begin
                    state_s      = IDLE;
                    last_grant_s = grant_r;
                end else if ((MAX_BEATS != 0) && (beat_cnt_r == CNT_LIMIT)) begin
                    state_s      = IDLE;
                    last_grant_s = grant_r;
                    pkt_err_s    = 1'b1;
                end else if (beat_cnt_r != {CNT_W{1'b1}}) begin
                    beat_cnt_s = beat_cnt_r + CNT_W'(1);
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers; reset drops any packet in flight without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= IDX_W'(N_REQ - 1);
            beat_cnt_r   <= '0;
            pkt_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            beat_cnt_r   <= beat_cnt_s;
            pkt_err_r    <= pkt_err_s;
        end
    end

endmodule
